// File: rtl/serial_checking_sink.sv
// Serial NoC local-port sink: deserialises start-bit framed flits, checks dst against ID, keeps stats.
// Optional latency statistics are built when SINK_LATENCY_EN is defined.
module serial_checking_sink #(
    parameter int ID          = 0,
    parameter int FLIT_W      = 8,
    parameter int ADDR_SZ     = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 32,
    parameter int TS_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data,
    output logic              busy,
    output logic              flit_valid,
    output logic [FLIT_W-1:0] last_flit,
    output logic [CNT_W-1:0]  flit_count,
    output logic [CNT_W-1:0]  err_count,
    output logic              proto_err,
    output logic [CNT_W-1:0]  lat_sum,
    output logic [TS_W-1:0]   lat_max
);
    localparam int BIT_W  = $clog2(FLIT_W);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [BIT_W-1:0]   LAST_BIT  = BIT_W'(FLIT_W - 1);
    localparam logic [HOLD_W-1:0]  LAST_HOLD = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [ADDR_SZ-1:0] MY_ID     = ADDR_SZ'(ID);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0]        state;
    logic [BIT_W-1:0]  bit_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [FLIT_W-1:0] shreg;
    logic              dst_ok;

    assign busy       = (state != IDLE);
    assign flit_valid = (state == CHECK);
    assign dst_ok     = (shreg[ADDR_SZ-1:0] == MY_ID);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            hold_cnt   <= '0;
            shreg      <= '0;
            last_flit  <= '0;
            flit_count <= '0;
            err_count  <= '0;
            proto_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (data) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    shreg[bit_cnt] <= data;
                    if (bit_cnt == LAST_BIT) state <= CHECK;
                    else                     bit_cnt <= bit_cnt + 1'b1;
                end
                CHECK: begin
                    last_flit <= shreg;
                    // saturating counters: hold at all-ones, never wrap
                    if (flit_count != '1)            flit_count <= flit_count + 1'b1;
                    if (!dst_ok && err_count != '1)  err_count  <= err_count + 1'b1;
                    hold_cnt <= '0;
                    state    <= (HOLD_CYCLES > 0) ? HOLD : IDLE;
                end
                HOLD: begin
                    // a 1 here would be a start bit sent into our busy window
                    if (data) proto_err <= 1'b1;
                    if (hold_cnt == LAST_HOLD) state <= IDLE;
                    else                       hold_cnt <= hold_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SINK_LATENCY_EN
    logic [TS_W-1:0]  ts_now;
    logic [TS_W-1:0]  lat;
    logic [CNT_W:0]   sum_ext;

    // modular subtraction handles timestamp wrap
    assign lat     = ts_now - shreg[FLIT_W-1 -: TS_W];
    assign sum_ext = {1'b0, lat_sum} + {{(CNT_W + 1 - TS_W){1'b0}}, lat};

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_now  <= '0;
            lat_sum <= '0;
            lat_max <= '0;
        end else begin
            ts_now <= ts_now + 1'b1;
            if (state == CHECK) begin
                lat_sum <= sum_ext[CNT_W] ? '1 : sum_ext[CNT_W-1:0];
                if (lat > lat_max) lat_max <= lat;
            end
        end
    end
`else
    assign lat_sum = '0;
    assign lat_max = '0;
`endif

endmodule
